mario_sprite_addr_gen: RTL and testbench
========================================

Name: mario_sprite_addr_gen

Overview:
- Directly upstream of the per-pose Mario sprite ROMs.
- Scans DrawX/DrawY against Mario's on-screen box and produces the ROM read_address, a pose select and an in_sprite flag.
- Runs the walk/jump animation state machine, stepped by the vsync-rate frame_clk.
- Output feeds the ROM bank mux and the colour mapper, where palette index 0 (purple) is treated as transparent.

Parameters:
- SPR_W, 21, sprite width in pixels.
- SPR_H, 41, sprite height in pixels; SPR_W*SPR_H = 861 ROM words.
- FRAMES_PER_STEP, 6, frame ticks per walk pose.
- SKID_FRAMES, 8, frame ticks spent in SKID (only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  vsync-rate strobe, asynchronous to the scan; rising edge = frame tick.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- MarioX  in  10  sprite top-left column.
- MarioY  in  10  sprite top-left row.
- walking  in  1  horizontal motion request.
- airborne  in  1  Mario not on ground.
- facing_left  in  1  direction.
- read_address  out  10  ROM address, 0..860.
- sprite_sel  out  3  pose: 0 STAND, 1 WALK1, 2 WALK2, 3 WALK3, 4 JUMP, 5 SKID.
- in_sprite  out  1  current pixel lies inside the sprite box.

Behaviour:
- Reset is synchronous and active-high; it wins over every simultaneous event.
- Reset values: state STAND, step counter 0, latched X/Y/facing 0, read_address 0, sprite_sel 0, in_sprite 0.
- frame_clk is double-flopped, then rising-edge detected. tick is a 1-Clk pulse, delayed 3 Clk from the edge.
- On tick: MarioX, MarioY and facing_left are latched (X_l, Y_l, face_l). No tearing mid-frame.
- Coordinates: dx = {1'b0,DrawX} - {1'b0,X_l}, 11-bit signed; dy likewise.
- in_box = (0 <= dx < SPR_W) && (0 <= dy < SPR_H). A negative difference never wraps into range.
- col = face_l ? (SPR_W-1-dx) : dx.
- addr = dy*SPR_W + col. Maximum is 860, which fits 10 bits.
- Outside the box, addr is forced to 0.
- Latency: read_address, in_sprite and sprite_sel are registered, valid 1 Clk after DrawX/DrawY are presented.
- sprite_sel is a registered copy of the state.
- State machine: transitions are evaluated only on tick. Priority order, highest first:
  - Reset → STAND.
  - airborne → JUMP, from any state.
  - !walking → STAND.
  - walking from STAND or JUMP → WALK1, counter cleared.
  - WALKn with walking: counter increments. At FRAMES_PER_STEP-1 the counter clears and the pose advances WALK1→WALK2→WALK3→WALK1 (wrap skips STAND).
- Counter clears on every state change. Counter width is $clog2(FRAMES_PER_STEP).
- Reset mid-walk: STAND next Clk; the first walking tick after reset enters WALK1.
- No tick in progress: the state holds indefinitely.

Optional Feature:
- Macro: MARIO_SKID_EN.
- When defined, on a tick in any WALKn state with walking=1 and face_l differing from the newly sampled facing_left, the state enters SKID (sprite_sel 5).
- SKID holds for SKID_FRAMES ticks, then goes to WALK1.
- Exits from SKID: airborne preempts to JUMP; !walking exits to STAND.
- When undefined, SKID is unreachable, sprite_sel never equals 5 and SKID_FRAMES is ignored.

Decomposition:
- Package mario_sprite_pkg holds:
  - anim_state_t enum with explicit 3-bit encodings equal to the sprite_sel values;
  - SPR_W_DEF and SPR_H_DEF constants.
- Sub-module frame_tick_sync: 2-flop synchroniser plus rising-edge detector. Inputs Clk, Reset, frame_clk; output tick.

Test Plan:
- Reset held 3 Clk with frame_clk toggling → all outputs 0, state STAND, no transition during reset.
- X=100, Y=200, facing right, tick, then DrawX=105, DrawY=203 → one Clk later read_address=3*21+5=68, in_sprite=1. DrawX=121 → in_sprite=0, read_address=0.
- Same as above with facing_left=1 latched → read_address=63+15=78. Changing facing_left without a tick → address stays 78.
- Boundary: X=0, DrawX=0 → in_sprite=1, col 0. X=630, DrawX=5 → in_sprite=0 (no wrap). Last pixel dx=20, dy=40 → read_address=860.
- walking=1 over 19 ticks from STAND → WALK1 at tick 1, WALK2 at tick 7, WALK3 at tick 13, WALK1 at tick 19. airborne=1 at next tick → JUMP. Reset asserted while WALK2 → STAND.
- MARIO_SKID_EN defined, WALK2, facing flips on tick → sprite_sel=5 for 8 ticks, then 1. Undefined → remains a walk pose.

Source files
------------

// File: rtl/mario_sprite_pkg.sv
// mario_sprite_pkg: animation pose encodings and default sprite geometry
package mario_sprite_pkg;
    typedef enum logic [2:0] {
        STAND = 3'd0,
        WALK1 = 3'd1,
        WALK2 = 3'd2,
        WALK3 = 3'd3,
        JUMP  = 3'd4,
        SKID  = 3'd5
    } anim_state_t;
    localparam int SPR_W_DEF = 21;
    localparam int SPR_H_DEF = 41;
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: synchronises the vsync-rate frame_clk and emits a 1-cycle
// registered tick per rising edge
module frame_tick_sync
    import mario_sprite_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic [2:0] sync;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync <= '0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], frame_clk};
            tick <= sync[1] & ~sync[2];
        end
    end
endmodule

// File: rtl/mario_sprite_addr_gen.sv
// mario_sprite_addr_gen: sprite ROM address, in-box flag and walk/jump pose FSM.
// Define MARIO_SKID_EN to add the SKID pose on direction reversal while walking.
module mario_sprite_addr_gen
    import mario_sprite_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF,
    parameter int FRAMES_PER_STEP = 6
`ifdef MARIO_SKID_EN
    , parameter int SKID_FRAMES = 8
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] MarioX,
    input  logic [9:0] MarioY,
    input  logic       walking,
    input  logic       airborne,
    input  logic       facing_left,
    output logic [9:0] read_address,
    output logic [2:0] sprite_sel,
    output logic       in_sprite
);
`ifdef MARIO_SKID_EN
    localparam int CW = $clog2(FRAMES_PER_STEP > SKID_FRAMES ? FRAMES_PER_STEP : SKID_FRAMES);
`else
    localparam int CW = $clog2(FRAMES_PER_STEP);
`endif
    logic          tick;
    anim_state_t   state;
    logic [CW-1:0] cnt;
    logic [9:0]    x_l, y_l, col, addr;
    logic          face_l, in_box;
    logic [10:0]   dx, dy;

    frame_tick_sync u_sync (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .tick(tick)
    );

    // zero-extended subtraction: bit 10 set means the pixel is left of / above the box
    always_comb begin
        dx = {1'b0, DrawX} - {1'b0, x_l};
        dy = {1'b0, DrawY} - {1'b0, y_l};
        in_box = !dx[10] && dx < 11'(SPR_W) && !dy[10] && dy < 11'(SPR_H);
        col = face_l ? 10'(SPR_W - 1) - dx[9:0] : dx[9:0];
        addr = in_box ? dy[9:0] * 10'(SPR_W) + col : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= STAND;
            cnt          <= '0;
            x_l          <= '0;
            y_l          <= '0;
            face_l       <= 1'b0;
            read_address <= '0;
            sprite_sel   <= '0;
            in_sprite    <= 1'b0;
        end else begin
            read_address <= addr;
            in_sprite    <= in_box;
            sprite_sel   <= state;
            if (tick) begin
                x_l    <= MarioX;
                y_l    <= MarioY;
                face_l <= facing_left;
                cnt    <= '0;
                if (airborne)
                    state <= JUMP;
                else if (!walking)
                    state <= STAND;
                else if (state == STAND || state == JUMP)
                    state <= WALK1;
`ifdef MARIO_SKID_EN
                else if (state != SKID && face_l != facing_left)
                    state <= SKID;
                else if (state == SKID) begin
                    if (cnt != CW'(SKID_FRAMES - 1))
                        cnt <= cnt + 1'b1;
                    else
                        state <= WALK1;
                end
`endif
                else if (cnt != CW'(FRAMES_PER_STEP - 1))
                    cnt <= cnt + 1'b1;
                else
                    state <= state == WALK3 ? WALK1 : anim_state_t'(state + 3'd1);
            end
        end
    end
endmodule

// File: tb/tb_mario_sprite_addr_gen.sv
// tb_mario_sprite_addr_gen: randomized and directed checks against a pose/address reference model
module tb_mario_sprite_addr_gen;
    logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0, MarioX = '0, MarioY = '0;
    logic       walking = 1'b0, airborne = 1'b0, facing_left = 1'b0;
    logic [9:0] read_address;
    logic [2:0] sprite_sel;
    logic       in_sprite;
`ifdef MARIO_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif
    int vectors = 0, errors = 0;
    int m_x = 0, m_y = 0, m_pose = 0, m_cnt = 0;
    bit m_face = 1'b0;

    mario_sprite_addr_gen dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
        .walking(walking), .airborne(airborne), .facing_left(facing_left),
        .read_address(read_address), .sprite_sel(sprite_sel), .in_sprite(in_sprite)
    );

    always #5 Clk = ~Clk;

    function automatic bit exp_in(int x, int y);
        return x >= m_x && x - m_x < 21 && y >= m_y && y - m_y < 41;
    endfunction

    function automatic int exp_addr(int x, int y);
        if (!exp_in(x, y)) return 0;
        return (y - m_y) * 21 + (m_face ? 20 - (x - m_x) : x - m_x);
    endfunction

    task automatic model_reset;
        m_x = 0; m_y = 0; m_face = 0; m_pose = 0; m_cnt = 0;
    endtask

    // pose rules: JUMP > STAND > enter WALK1 > skid > walk stepping
    task automatic model_tick;
        int np;
        np = m_pose;
        if (airborne) np = 4;
        else if (!walking) np = 0;
        else if (m_pose == 0 || m_pose == 4) np = 1;
        else if (SKID_EN && m_pose != 5 && m_face != facing_left) np = 5;
        else if (m_pose == 5) begin
            if (m_cnt == 7) np = 1; else m_cnt++;
        end else begin
            if (m_cnt == 5) np = (m_pose == 3) ? 1 : m_pose + 1; else m_cnt++;
        end
        if (np != m_pose || airborne || !walking) m_cnt = 0;
        m_pose = np;
        m_x = MarioX; m_y = MarioY; m_face = facing_left;
    endtask

    task automatic do_tick;
        model_tick();
        frame_clk = 1'b1;
        repeat (6) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
    endtask

    task automatic apply_pix(input int x, input int y);
        DrawX = 10'(x); DrawY = 10'(y);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        walking = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame_clk = ~frame_clk;
            @(posedge Clk);
            #1;
            vectors++;
            if (read_address !== 10'd0 || in_sprite !== 1'b0 || sprite_sel !== 3'd0) begin
                errors++;
                $display("FAIL reset_%0d: addr=%0d in=%b sel=%0d want 0 0 0", i, read_address, in_sprite, sprite_sel);
            end
        end
        frame_clk = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
        repeat (8) @(posedge Clk);
        #1;
        vectors++;
        if (sprite_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_no_tick: sel=%0d want 0", sprite_sel);
        end
        walking = 1'b0;
    endtask

    task automatic test_address;
        MarioX = 10'd100; MarioY = 10'd200; facing_left = 1'b0;
        do_tick();
        apply_pix(105, 203);
        vectors++;
        if (read_address !== 10'd68 || in_sprite !== 1'b1) begin
            errors++;
            $display("FAIL addr_basic: addr=%0d in=%b want 68 1", read_address, in_sprite);
        end
        apply_pix(121, 203);
        vectors++;
        if (read_address !== 10'd0 || in_sprite !== 1'b0) begin
            errors++;
            $display("FAIL addr_right_edge: addr=%0d in=%b want 0 0", read_address, in_sprite);
        end
    endtask

    task automatic test_mirror;
        facing_left = 1'b1;
        do_tick();
        apply_pix(105, 203);
        vectors++;
        if (read_address !== 10'd78 || in_sprite !== 1'b1) begin
            errors++;
            $display("FAIL mirror: addr=%0d in=%b want 78 1", read_address, in_sprite);
        end
        facing_left = 1'b0;
        repeat (5) @(posedge Clk);
        apply_pix(105, 203);
        vectors++;
        if (read_address !== 10'd78) begin
            errors++;
            $display("FAIL mirror_no_tear: addr=%0d want 78", read_address);
        end
    endtask

    task automatic test_boundary;
        MarioX = 10'd0; MarioY = 10'd0; facing_left = 1'b0;
        do_tick();
        apply_pix(0, 0);
        vectors++;
        if (read_address !== 10'd0 || in_sprite !== 1'b1) begin
            errors++;
            $display("FAIL bound_origin: addr=%0d in=%b want 0 1", read_address, in_sprite);
        end
        MarioX = 10'd630;
        do_tick();
        apply_pix(5, 0);
        vectors++;
        if (read_address !== 10'd0 || in_sprite !== 1'b0) begin
            errors++;
            $display("FAIL bound_nowrap: addr=%0d in=%b want 0 0", read_address, in_sprite);
        end
        MarioX = 10'd100; MarioY = 10'd200;
        do_tick();
        apply_pix(120, 240);
        vectors++;
        if (read_address !== 10'd860 || in_sprite !== 1'b1) begin
            errors++;
            $display("FAIL bound_last: addr=%0d in=%b want 860 1", read_address, in_sprite);
        end
        apply_pix(100, 241);
        vectors++;
        if (read_address !== 10'd0 || in_sprite !== 1'b0) begin
            errors++;
            $display("FAIL bound_below: addr=%0d in=%b want 0 0", read_address, in_sprite);
        end
        apply_pix(99, 200);
        vectors++;
        if (read_address !== 10'd0 || in_sprite !== 1'b0) begin
            errors++;
            $display("FAIL bound_left: addr=%0d in=%b want 0 0", read_address, in_sprite);
        end
    endtask

    task automatic test_walk;
        int want;
        walking = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            do_tick();
            want = (t == 1 || t == 19) ? 1 : (t == 7) ? 2 : (t == 13) ? 3 : m_pose;
            vectors++;
            if (sprite_sel !== 3'(m_pose) || m_pose != want) begin
                errors++;
                $display("FAIL walk_tick%0d: sel=%0d want %0d", t, sprite_sel, want);
            end
        end
        airborne = 1'b1;
        do_tick();
        vectors++;
        if (sprite_sel !== 3'd4) begin
            errors++;
            $display("FAIL jump: sel=%0d want 4", sprite_sel);
        end
        airborne = 1'b0;
        for (int t = 0; t < 7; t++) do_tick();
        vectors++;
        if (sprite_sel !== 3'd2) begin
            errors++;
            $display("FAIL walk2_before_reset: sel=%0d want 2", sprite_sel);
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        model_reset();
        vectors++;
        if (sprite_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_midwalk: sel=%0d want 0", sprite_sel);
        end
        Reset = 1'b0;
        do_tick();
        vectors++;
        if (sprite_sel !== 3'd1) begin
            errors++;
            $display("FAIL walk_after_reset: sel=%0d want 1", sprite_sel);
        end
    endtask

    task automatic test_skid;
        for (int t = 0; t < 6; t++) do_tick();
        vectors++;
        if (sprite_sel !== 3'd2) begin
            errors++;
            $display("FAIL skid_setup: sel=%0d want 2", sprite_sel);
        end
        facing_left = ~facing_left;
        do_tick();
        vectors++;
        if (sprite_sel !== (SKID_EN ? 3'd5 : 3'd2)) begin
            errors++;
            $display("FAIL skid_enter: sel=%0d want %0d", sprite_sel, SKID_EN ? 5 : 2);
        end
        for (int t = 1; t <= 8; t++) begin
            do_tick();
            vectors++;
            if (sprite_sel !== 3'(m_pose) || (SKID_EN && m_pose != (t < 8 ? 5 : 1))) begin
                errors++;
                $display("FAIL skid_hold%0d: sel=%0d want %0d", t, sprite_sel, m_pose);
            end
        end
    endtask

    task automatic test_random;
        int x, y;
        for (int i = 0; i < 40; i++) begin
            MarioX = 10'($urandom_range(0, 639));
            MarioY = 10'($urandom_range(0, 479));
            facing_left = 1'($urandom);
            walking = ($urandom % 4) != 0;
            airborne = ($urandom % 5) == 0;
            do_tick();
            vectors++;
            if (sprite_sel !== 3'(m_pose)) begin
                errors++;
                $display("FAIL rand_pose%0d: sel=%0d want %0d", i, sprite_sel, m_pose);
            end
            for (int k = 0; k < 6; k++) begin
                x = m_x + $urandom_range(0, 30) - 5;
                y = m_y + $urandom_range(0, 50) - 5;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (x > 1023) x = 1023;
                if (y > 1023) y = 1023;
                apply_pix(x, y);
                vectors++;
                if (read_address !== 10'(exp_addr(x, y)) || in_sprite !== exp_in(x, y)) begin
                    errors++;
                    $display("FAIL rand_pix%0d_%0d: (%0d,%0d) addr=%0d in=%b want %0d %b",
                             i, k, x, y, read_address, in_sprite, exp_addr(x, y), exp_in(x, y));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_address();
        test_mirror();
        test_boundary();
        test_walk();
        test_skid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
